// File: rtl/twiddle_trivial_seq.sv
// Trivial-twiddle rotator: multiplies each frame sample by (-j)^k or (+j)^k,
// with k derived from the sample index, behind a single valid/ready output register.
module twiddle_trivial_seq #(
  parameter int unsigned FRAME_LOG2 = 6
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [31:0] DIN,
  input  logic        DIN_VALID,
  input  logic        DIN_SOF,
  output logic        DIN_READY,
  input  logic        INV,
  output logic [31:0] DOUT,
  output logic [2:0]  DOUT_TYPE,
  output logic        DOUT_VALID,
  output logic        DOUT_EOF,
  input  logic        DOUT_READY
);

  localparam int unsigned NW = FRAME_LOG2;
  localparam int unsigned HW = 16;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [NW-1:0] n_q, n_d, n_cur;
  logic          inv_q, inv_d, inv_eff;
  logic          accept_c, emit_c, eof_c;
  logic [1:0]    k_c, k_eff_c;
  logic [2:0]    type_c;
  logic [HW-1:0] re_c, im_c, sw_re_c, sw_im_c;
  logic [31:0]   rot_c;

  // Two's complement negation with -32768 clamped to +32767
  function automatic logic [HW-1:0] neg_sat(input logic [HW-1:0] x);
    if (x == {1'b1, {(HW-1){1'b0}}}) return {1'b0, {(HW-1){1'b1}}};
    return HW'(~x + HW'(1));
  endfunction

  assign DIN_READY = !DOUT_VALID || DOUT_READY;
  assign accept_c  = DIN_VALID && DIN_READY;
  assign emit_c    = accept_c && (state_q == RUN || DIN_SOF);

  // SOF forces index 0 and uses the live INV, which is latched for the rest of the frame
  assign n_cur   = DIN_SOF ? '0 : n_q;
  assign inv_eff = DIN_SOF ? INV : inv_q;
  assign k_c     = n_cur[NW-1:NW-2] * n_cur[1:0];
  assign k_eff_c = inv_eff ? 2'(2'd0 - k_c) : k_c;
  assign eof_c   = (n_cur == {NW{1'b1}});

  always_comb begin
    type_c = 3'b000;
    case (k_eff_c)
      2'd0: type_c = 3'b000;
      2'd1: type_c = 3'b101;
      2'd2: type_c = 3'b011;
      2'd3: type_c = 3'b110;
      default: type_c = 3'b000;
    endcase
  end

  always_comb begin
    re_c    = DIN[31:16];
    im_c    = DIN[15:0];
    sw_re_c = type_c[2] ? im_c : re_c;
    sw_im_c = type_c[2] ? re_c : im_c;
    rot_c   = {(type_c[1] ? neg_sat(sw_re_c) : sw_re_c),
               (type_c[0] ? neg_sat(sw_im_c) : sw_im_c)};
  end

  // Next-state: frame tracking, index counter and INV latch
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    inv_d   = inv_q;
    if (accept_c && DIN_SOF) begin
      state_d = RUN;
      inv_d   = INV;
    end
    if (emit_c) n_d = NW'(n_cur + NW'(1));
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      n_q     <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      inv_q   <= inv_d;
    end
  end

  // Output register; holds while downstream stalls
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      DOUT       <= '0;
      DOUT_TYPE  <= 3'b000;
      DOUT_VALID <= 1'b0;
      DOUT_EOF   <= 1'b0;
    end else if (DIN_READY) begin
      DOUT_VALID <= emit_c;
      if (emit_c) begin
        DOUT      <= rot_c;
        DOUT_TYPE <= type_c;
        DOUT_EOF  <= eof_c;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_trivial_seq.sv
// Bench for twiddle_trivial_seq: directed frames plus random traffic against a
// complex-rotation reference model.
module tb_twiddle_trivial_seq;

  localparam int unsigned FL2   = 6;
  localparam int          FRAME = 1 << FL2;

  logic        CLK, RSTN;
  logic [31:0] DIN;
  logic        DIN_VALID, DIN_SOF, DIN_READY, INV;
  logic [31:0] DOUT;
  logic [2:0]  DOUT_TYPE;
  logic        DOUT_VALID, DOUT_EOF, DOUT_READY;

  twiddle_trivial_seq #(.FRAME_LOG2(FL2)) dut (
    .CLK(CLK), .RSTN(RSTN), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_SOF(DIN_SOF),
    .DIN_READY(DIN_READY), .INV(INV), .DOUT(DOUT), .DOUT_TYPE(DOUT_TYPE),
    .DOUT_VALID(DOUT_VALID), .DOUT_EOF(DOUT_EOF), .DOUT_READY(DOUT_READY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int passes = 0;

  // reference model state
  logic        ref_valid;
  logic [31:0] ref_dout;
  logic [2:0]  ref_type;
  logic        ref_eof;
  int          ref_n;
  logic        running;
  int          cnt;
  logic        inv_l;

  logic [31:0] cap_dout [FRAME];
  logic [2:0]  cap_type [FRAME];
  logic        cap_eof  [FRAME];
  int          eof_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [15:0] sneg(input logic [15:0] x);
    int v;
    v = int'(signed'(x));
    if (v == -32768) return 16'h7FFF;
    return 16'(-v);
  endfunction

  // multiply (a + jb) by the unit rotation selected by keff: 1, -j, -1, +j
  function automatic logic [31:0] rotate(input logic [31:0] d, input int keff);
    logic [15:0] a, b;
    a = d[31:16];
    b = d[15:0];
    case (keff)
      1:       return {b, sneg(a)};
      2:       return {sneg(a), sneg(b)};
      3:       return {sneg(b), a};
      default: return d;
    endcase
  endfunction

  function automatic logic [2:0] type_of(input int keff);
    case (keff)
      1:       return 3'b101;
      2:       return 3'b011;
      3:       return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    ref_valid = 1'b0; ref_dout = '0; ref_type = '0; ref_eof = 1'b0;
    running = 1'b0; cnt = 0; inv_l = 1'b0;
  endtask

  // one clock: drive at negedge, check registered outputs, advance the model
  task automatic step(input logic v, input logic sof, input logic [31:0] d,
                      input logic inv, input logic rdy);
    logic exp_rdy;
    int   n, k, keff;
    @(negedge CLK);
    DIN_VALID = v; DIN_SOF = sof; DIN = d; INV = inv; DOUT_READY = rdy;
    #1;
    exp_rdy = !ref_valid || rdy;
    chk("din_ready", 32'(DIN_READY), 32'(exp_rdy));
    chk("dout_valid", 32'(DOUT_VALID), 32'(ref_valid));
    if (ref_valid) begin
      chk("dout", DOUT, ref_dout);
      chk("dout_type", 32'(DOUT_TYPE), 32'(ref_type));
      chk("dout_eof", 32'(DOUT_EOF), 32'(ref_eof));
      if (rdy) begin
        cap_dout[ref_n] = DOUT;
        cap_type[ref_n] = DOUT_TYPE;
        cap_eof[ref_n]  = DOUT_EOF;
        if (DOUT_EOF) eof_seen++;
      end
    end
    if (exp_rdy) ref_valid = 1'b0;
    if (v && exp_rdy) begin
      if (sof) begin running = 1'b1; cnt = 0; inv_l = inv; end
      if (running) begin
        n = cnt;
        k = ((n >> (FL2 - 2)) * (n % 4)) % 4;
        keff = inv_l ? (4 - k) % 4 : k;
        ref_valid = 1'b1;
        ref_n     = n;
        ref_dout  = rotate(d, keff);
        ref_type  = type_of(keff);
        ref_eof   = (n == FRAME - 1);
        cnt       = (n + 1) % FRAME;
      end
    end
  endtask

  initial begin
    int e0;
    logic [31:0] d;
    DIN = '0; DIN_VALID = 1'b0; DIN_SOF = 1'b0; INV = 1'b0; DOUT_READY = 1'b1;
    RSTN = 1'b0;
    model_reset();
    repeat (3) @(posedge CLK);
    #2;
    chk("rst_dout", DOUT, 32'h0);
    chk("rst_type", 32'(DOUT_TYPE), 32'h0);
    chk("rst_valid", 32'(DOUT_VALID), 32'h0);
    chk("rst_eof", 32'(DOUT_EOF), 32'h0);
    chk("rst_din_ready", 32'(DIN_READY), 32'h1);
    @(negedge CLK);
    RSTN = 1'b1;

    // non-SOF samples in IDLE are dropped
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("idle_no_valid", 32'(DOUT_VALID), 32'h0);

    // frame A: constant data, forward rotation
    for (int i = 0; i < FRAME; i++) step(1'b1, i == 0, 32'h1000_2000, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("a_n16", cap_dout[16], 32'h1000_2000);
    chk("a_n16_type", 32'(cap_type[16]), 32'h0);
    chk("a_n17", cap_dout[17], 32'h2000_F000);
    chk("a_n17_type", 32'(cap_type[17]), 32'h5);
    chk("a_n34", cap_dout[34], 32'h1000_2000);
    chk("a_n63", cap_dout[63], 32'h2000_F000);
    chk("a_n63_type", 32'(cap_type[63]), 32'h5);
    chk("a_n63_eof", 32'(cap_eof[63]), 32'h1);
    chk("a_n62_eof", 32'(cap_eof[62]), 32'h0);

    // frame B: inverse, INV toggled mid-frame must be ignored
    for (int i = 0; i < FRAME; i++)
      step(1'b1, i == 0, 32'h1000_2000, (i == 0) ? 1'b1 : 1'($urandom), 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("b_n17", cap_dout[17], 32'hE000_1000);
    chk("b_n17_type", 32'(cap_type[17]), 32'h6);
    chk("b_n42", cap_dout[42], 32'h1000_2000);
    chk("b_n42_type", 32'(cap_type[42]), 32'h0);
    chk("b_n43", cap_dout[43], 32'hF000_E000);
    chk("b_n43_type", 32'(cap_type[43]), 32'h3);

    // frame C: random data, saturation at n=43, 5-cycle downstream stall at n=30
    for (int i = 0; i < FRAME; i++) begin
      d = (i == 43) ? 32'h8000_8000 : $urandom;
      if (i == 30) begin
        for (int s = 0; s < 5; s++) begin
          step(1'b1, 1'b0, d, 1'b0, 1'b0);
          chk("stall_din_ready", 32'(DIN_READY), 32'h0);
        end
      end
      step(1'b1, i == 0, d, 1'b0, 1'b1);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("c_sat", cap_dout[43], 32'h7FFF_7FFF);
    chk("c_sat_type", 32'(cap_type[43]), 32'h3);
    chk("c_eof", 32'(cap_eof[63]), 32'h1);

    // short frame: SOF at n=30 restarts without an EOF
    e0 = eof_seen;
    for (int i = 0; i < 30; i++) step(1'b1, i == 0, $urandom, 1'b0, 1'b1);
    step(1'b1, 1'b1, $urandom, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h1000_2000, 1'b0, 1'b1);
    chk("short_sof_type", 32'(DOUT_TYPE), 32'h0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("short_n1_dout", DOUT, 32'h1000_2000);
    chk("short_n1_type", 32'(DOUT_TYPE), 32'h0);
    chk("short_no_eof", 32'(eof_seen), 32'(e0));
    for (int i = 2; i < FRAME; i++) step(1'b1, 1'b0, $urandom, 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("short_full_eof", 32'(eof_seen), 32'(e0 + 1));

    // random traffic: bursty valid/ready, rare SOF, random INV
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) != 0, ($urandom % 50) == 0, $urandom, 1'($urandom),
           ($urandom % 3) != 0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // mid-frame reset with the output register full at n=20
    for (int i = 0; i <= 20; i++) step(1'b1, i == 0, $urandom, 1'b0, 1'b1);
    @(posedge CLK);
    #2;
    DIN_VALID = 1'b0;
    chk("pre_rst_valid", 32'(DOUT_VALID), 32'h1);
    RSTN = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(DOUT_VALID), 32'h0);
    chk("mid_rst_dout", DOUT, 32'h0);
    chk("mid_rst_type", 32'(DOUT_TYPE), 32'h0);
    chk("mid_rst_din_ready", 32'(DIN_READY), 32'h1);
    model_reset();
    @(negedge CLK);
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom, 1'b1, 1'b1);
    step(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h1000_2000, 1'b0, 1'b1);
    chk("post_rst_first", DOUT, 32'h1234_5678);
    chk("post_rst_first_type", 32'(DOUT_TYPE), 32'h0);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
